// File: rtl/down_count_pkg.sv
// Shared state encoding and width helper for the down-count controller.
package down_count_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_RUN  = 2'd1;
    localparam logic [1:0] STATE_HOLD = 2'd2;
    localparam logic [1:0] STATE_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = STATE_IDLE,
        RUN  = STATE_RUN,
        HOLD = STATE_HOLD,
        DONE = STATE_DONE
    } state_t;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w = 1;
        while ((32'd1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/down_count_controller_if.sv
// Control/status bundle between the surrounding control logic and the controller.
interface down_count_controller_if #(
    parameter int unsigned WIDTH = 3
) ();
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             abort;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             step;
    logic             done;

    modport master (
        output load_val, start, pause, abort, auto_reload,
        input  count, busy, step, done
    );

    modport slave (
        input  load_val, start, pause, abort, auto_reload,
        output count, busy, step, done
    );
endinterface

// File: rtl/down_count_controller_prescaler.sv
// Step prescaler: counts enabled clocks and flags the wrap from PRESCALE-1 to 0.
module count_prescaler
    import down_count_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int unsigned    PW   = clog2_min1(PRESCALE);
    localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);
    assign tick      = en && w_at_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_at_last ? '0 : r_cnt + PW'(1);
        end
    end
endmodule

// File: rtl/down_count_controller.sv
// Supervised countdown: load, decrement every PRESCALE clocks, pulse done at zero.
module down_count_controller
    import down_count_pkg::*;
#(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    down_count_controller_if.slave bus
);
    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nx;
    logic             r_busy;
    logic             r_step;
    logic             r_done;
    logic             w_step_nx;
    logic             w_busy_nx;
    logic             w_done_nx;
    logic             w_load_nz;
    logic             w_load_ok;
    logic             w_presc_en;
    logic             w_presc_clr;
    logic             w_tick;

    assign w_load_nz   = (bus.load_val != '0);
    assign w_load_ok   = !bus.abort &&
                         (((r_state == IDLE) && bus.start) ||
                          ((r_state == DONE) && (bus.start || bus.auto_reload)));
    assign w_presc_clr = bus.abort || w_load_ok;
    // Leaving HOLD with pause low counts as a running cycle so each paused cycle costs one clock.
    assign w_presc_en  = !bus.abort && !bus.pause &&
                         ((r_state == RUN) || (r_state == HOLD));

    count_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (w_presc_en),
        .clr  (w_presc_clr),
        .tick (w_tick)
    );

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_step_nx  = 1'b0;
        if (bus.abort) begin
            w_state_nx = IDLE;
            w_count_nx = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_load_nz) begin
                            w_count_nx = bus.load_val;
                            w_state_nx = RUN;
                        end else begin
                            w_count_nx = '0;
                            w_state_nx = DONE;
                        end
                    end
                end
                RUN, HOLD: begin
                    if (bus.pause) begin
                        w_state_nx = HOLD;
                    end else begin
                        w_state_nx = RUN;
                        if (w_tick && (r_count != '0)) begin
                            w_count_nx = r_count - WIDTH'(1);
                            w_step_nx  = 1'b1;
                            if (r_count == WIDTH'(1)) w_state_nx = DONE;
                        end
                    end
                end
                DONE: begin
                    w_count_nx = '0;
                    if (bus.start || bus.auto_reload) begin
                        if (w_load_nz) begin
                            w_count_nx = bus.load_val;
                            w_state_nx = RUN;
                        end else begin
                            w_state_nx = DONE;
                        end
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_count_nx = '0;
                end
            endcase
        end
        w_busy_nx = (w_state_nx == RUN) || (w_state_nx == HOLD);
        w_done_nx = (w_state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_step  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_busy  <= w_busy_nx;
            r_step  <= w_step_nx;
            r_done  <= w_done_nx;
        end
    end

    assign bus.count = r_count;
    assign bus.busy  = r_busy;
    assign bus.step  = r_step;
    assign bus.done  = r_done;
endmodule

// File: tb/tb_down_count_controller.sv
// Directed bench: vector table on a PRESCALE=1 instance, hand sequence on PRESCALE=4.
module tb_down_count_controller;

    typedef struct {
        logic       rst;
        logic       start;
        logic       pause;
        logic       abort;
        logic       auto_reload;
        logic [2:0] load_val;
        logic [2:0] exp_count;
        logic       exp_busy;
        logic       exp_step;
        logic       exp_done;
    } vec_t;

    logic clk  = 1'b0;
    logic rst1 = 1'b1;
    logic rst4 = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    down_count_controller_if #(.WIDTH(3)) if1 ();
    down_count_controller_if #(.WIDTH(3)) if4 ();

    down_count_controller #(.WIDTH(3), .PRESCALE(1)) u_dut1 (
        .clk (clk), .rst (rst1), .bus (if1)
    );
    down_count_controller #(.WIDTH(3), .PRESCALE(4)) u_dut4 (
        .clk (clk), .rst (rst4), .bus (if4)
    );

    function automatic vec_t v(input logic r, input logic st, input logic pa,
                               input logic ab, input logic ar, input logic [2:0] lv,
                               input logic [2:0] ec, input logic eb, input logic es,
                               input logic ed);
        vec_t x;
        x.rst = r; x.start = st; x.pause = pa; x.abort = ab; x.auto_reload = ar;
        x.load_val = lv; x.exp_count = ec; x.exp_busy = eb; x.exp_step = es;
        x.exp_done = ed;
        return x;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        if1.load_val = 3'd0; if1.start = 1'b0; if1.pause = 1'b0;
        if1.abort = 1'b0;    if1.auto_reload = 1'b0;
        if4.load_val = 3'd0; if4.start = 1'b0; if4.pause = 1'b0;
        if4.abort = 1'b0;    if4.auto_reload = 1'b0;

        // reset
        vecs.push_back(v(1,0,0,0,0,0, 0,0,0,0));
        // basic countdown from 5
        vecs.push_back(v(0,1,0,0,0,5, 5,1,0,0));
        vecs.push_back(v(0,0,0,0,0,5, 4,1,1,0));
        vecs.push_back(v(0,0,0,0,0,5, 3,1,1,0));
        vecs.push_back(v(0,0,0,0,0,5, 2,1,1,0));
        vecs.push_back(v(0,0,0,0,0,5, 1,1,1,0));
        vecs.push_back(v(0,0,0,0,0,5, 0,0,1,1));
        vecs.push_back(v(0,0,0,0,0,5, 0,0,0,0));
        // zero load goes straight to DONE
        vecs.push_back(v(0,1,0,0,0,0, 0,0,0,1));
        vecs.push_back(v(0,0,0,0,0,0, 0,0,0,0));
        // auto-reload of 3
        vecs.push_back(v(0,1,0,0,1,3, 3,1,0,0));
        vecs.push_back(v(0,0,0,0,1,3, 2,1,1,0));
        vecs.push_back(v(0,0,0,0,1,3, 1,1,1,0));
        vecs.push_back(v(0,0,0,0,1,3, 0,0,1,1));
        vecs.push_back(v(0,0,0,0,1,3, 3,1,0,0));
        vecs.push_back(v(0,0,0,0,1,3, 2,1,1,0));
        vecs.push_back(v(0,0,0,0,1,3, 1,1,1,0));
        vecs.push_back(v(0,0,0,0,1,3, 0,0,1,1));
        vecs.push_back(v(0,0,0,0,0,3, 0,0,0,0));
        // abort at count 4, with pause also high
        vecs.push_back(v(0,1,0,0,0,7, 7,1,0,0));
        vecs.push_back(v(0,0,0,0,0,7, 6,1,1,0));
        vecs.push_back(v(0,0,0,0,0,7, 5,1,1,0));
        vecs.push_back(v(0,0,0,0,0,7, 4,1,1,0));
        vecs.push_back(v(0,0,1,1,0,7, 0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,7, 0,0,0,0));
        // reset mid-countdown
        vecs.push_back(v(0,1,0,0,0,7, 7,1,0,0));
        vecs.push_back(v(0,0,0,0,0,7, 6,1,1,0));
        vecs.push_back(v(1,0,0,0,0,7, 0,0,0,0));
        vecs.push_back(v(0,0,0,0,0,7, 0,0,0,0));
        // start while busy (RUN and HOLD) is ignored
        vecs.push_back(v(0,1,0,0,0,4, 4,1,0,0));
        vecs.push_back(v(0,1,0,0,0,7, 3,1,1,0));
        vecs.push_back(v(0,1,1,0,0,7, 3,1,0,0));
        vecs.push_back(v(0,1,1,0,0,7, 3,1,0,0));
        vecs.push_back(v(0,0,0,0,0,7, 2,1,1,0));
        vecs.push_back(v(0,0,0,0,0,7, 1,1,1,0));
        vecs.push_back(v(0,0,0,0,0,7, 0,0,1,1));
        vecs.push_back(v(0,0,0,0,0,7, 0,0,0,0));

        foreach (vecs[i]) begin
            rst1             = vecs[i].rst;
            if1.start        = vecs[i].start;
            if1.pause        = vecs[i].pause;
            if1.abort        = vecs[i].abort;
            if1.auto_reload  = vecs[i].auto_reload;
            if1.load_val     = vecs[i].load_val;
            @(posedge clk); #1;
            chk("count", i, int'(if1.count), int'(vecs[i].exp_count));
            chk("busy",  i, int'(if1.busy),  int'(vecs[i].exp_busy));
            chk("step",  i, int'(if1.step),  int'(vecs[i].exp_step));
            chk("done",  i, int'(if1.done),  int'(vecs[i].exp_done));
        end

        // PRESCALE=4, load 2, pause sampled high at edges 5..7: decrements at 4 and 11
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        chk("p4_rst_count", 0, int'(if4.count), 0);
        chk("p4_rst_done",  0, int'(if4.done),  0);
        if4.load_val = 3'd2;
        if4.start    = 1'b1;
        @(posedge clk); #1;
        if4.start = 1'b0;
        chk("p4_count", 0, int'(if4.count), 2);
        chk("p4_busy",  0, int'(if4.busy),  1);
        for (int e = 1; e <= 12; e++) begin
            if4.pause = (e >= 5 && e <= 7);
            @(posedge clk); #1;
            chk("p4_count", e, int'(if4.count), (e < 4) ? 2 : ((e < 11) ? 1 : 0));
            chk("p4_step",  e, int'(if4.step),  (e == 4 || e == 11) ? 1 : 0);
            chk("p4_done",  e, int'(if4.done),  (e == 11) ? 1 : 0);
            chk("p4_busy",  e, int'(if4.busy),  (e < 11) ? 1 : 0);
        end
        if4.pause = 1'b0;

        // PRESCALE=4 zero load: DONE next cycle, no step
        if4.load_val = 3'd0;
        if4.start    = 1'b1;
        @(posedge clk); #1;
        if4.start = 1'b0;
        chk("p4_zero_done", 0, int'(if4.done),  1);
        chk("p4_zero_step", 0, int'(if4.step),  0);
        chk("p4_zero_cnt",  0, int'(if4.count), 0);
        @(posedge clk); #1;
        chk("p4_zero_done", 1, int'(if4.done),  0);
        chk("p4_zero_busy", 1, int'(if4.busy),  0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/down_count_controller.md
# down_count_controller

Sequencing controller for the team's down-counter datapath. It loads a start value, then decrements it once every PRESCALE clocks until it reaches zero, and signals completion with a one-cycle done pulse. Software-style controls (start, pause, abort, auto-reload) arrive from the surrounding control logic. The block replaces free-running ripple counting with a fully synchronous, single-clock, supervised countdown.

## Interface
- WIDTH, 3: width of count value and load value.
- PRESCALE, 1: clocks per decrement step; legal range 1..256.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_val  input  WIDTH  start value, sampled on an accepted start or reload.
- start  input  1  level-sampled request to begin a countdown; ignored while busy.
- pause  input  1  while high in RUN/HOLD, freezes count and prescaler.
- abort  input  1  terminates any activity and returns to IDLE.
- auto_reload  input  1  sampled in DONE; selects restart with load_val.
- count  output  WIDTH  current count value (registered).
- busy  output  1  high in RUN or HOLD.
- step  output  1  one-cycle pulse on the cycle after each decrement.
- done  output  1  one-cycle pulse: high exactly while the state is DONE.

## Operation
- States: IDLE, RUN, HOLD, DONE. Reset → IDLE, count=0, prescaler=0, busy=0, step=0, done=0.
- Priority in every state: rst > abort > pause > start/step.
- **IDLE**
  - start=1 with load_val≠0: count←load_val, prescaler←0, go to RUN.
  - start=1 with load_val=0: go directly to DONE.
- **RUN**
  - pause=1: go to HOLD; no prescaler advance and no decrement that cycle.
  - Otherwise the prescaler increments. At PRESCALE-1 it wraps to 0 and a step occurs: count←count-1, step←1.
  - If that step takes count from 1 to 0: go to DONE.
- **HOLD**
  - count and prescaler are frozen.
  - pause=0: return to RUN; the prescaler resumes from its held value.
- **DONE**
  - count=0, done=1.
  - On the next edge, auto_reload=1 or start=1 reloads: count←load_val, prescaler←0, go to RUN (or stay in DONE if load_val=0).
  - Otherwise go to IDLE.
- **abort** in any state: count←0, prescaler←0, go to IDLE. No done pulse. A step pulse due the same cycle is suppressed.
- **Width and arithmetic rules**
  - count never wraps below 0; a decrement is only issued when count≥1.
  - The prescaler width is clog2(PRESCALE), minimum 1 bit.

## Timing
- start sampled at edge 0 with load_val=N>0: count=N and busy=1 after edge 0.
- With PRESCALE=P, decrements occur at edges P, 2P, …, N·P.
- After edge N·P: state=DONE, count=0, done=1, busy=0 for exactly one cycle.
- step is high for one cycle after each of edges P..N·P, including the final one.
- Each pause cycle extends the total latency by exactly one clock.
- rst asserted mid-countdown: all outputs reach their reset values after that edge, with no done pulse.
- start arriving in the same cycle as a step in RUN is ignored (no restart).

## Structure
- Shared package/include `down_count_pkg`:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3);
  - the clog2 helper.
- One sub-module: `count_prescaler`.
  - Ports: clk, rst, en, clr, tick.
  - Parameterized by PRESCALE; emits tick when wrapping from PRESCALE-1 to 0.
- Top level: FSM, count register, output registers.

## Test plan
- **Basic countdown.** Reset, then WIDTH=3, PRESCALE=1, load_val=5, start pulse at edge 0.
  - count 5,4,3,2,1,0 on consecutive cycles.
  - done high for one cycle after edge 5; IDLE after edge 6.
- **Prescale with pause.** PRESCALE=4, load_val=2; pause held 3 cycles during RUN.
  - Decrements at edges 4 and 11; count frozen while paused.
  - done after edge 11.
- **Zero load.** load_val=0 with start.
  - DONE the next cycle, count=0, step never asserted.
- **Auto-reload.** auto_reload=1, load_val=3, PRESCALE=1.
  - Sequence 3,2,1,0,3,2,1,0; done pulses one cycle after each 0 reached.
- **Abort and reset mid-run.** abort at count=4 (load_val=7).
  - count=0, IDLE next cycle, no done pulse.
  - Repeat with rst: all outputs 0 after that edge.
- **Start while busy.** start pulses during RUN and HOLD are ignored.
  - count trajectory unchanged versus the reference run.
